turf_cin_autotrain: RTL and testbench
=====================================

Name: turf_cin_autotrain

Overview:
- Sysclk-domain sequencer that trains the TURF CIN command path without software stepping.
- Resets the CIN ISERDES and parallel sync, then sweeps all 64 IDELAY taps while counting bit errors, and loads the centre of the widest clean eye.
- Bitslips until captured data is bit-aligned to the training pattern, then requests lock and waits for it.
- Sits beside the register core; a mux outside this block selects between its outputs and the register-driven controls.

Parameters:
- TRAIN_SEQUENCE, 32'hA55A6996, training word the CIN path carries while in training mode.
- SETTLE_CYCLES, 64, wait after each IDELAY load or bitslip before sampling (covers the CDC to rxclk).
- DWELL_CYCLES, 4096, bit-error observation window per tap.
- MIN_EYE, 4, minimum clean-run length (taps) accepted as an eye.
- CAPTURE_WAIT, 16, cycles from capture pulse until cin_sync_data_i is valid.
- LOCK_TIMEOUT, 1024, cycles allowed for cin_sync_locked_i after the lock pulse.

Ports:
- sysclk_i  in  1  clock (all logic).
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin training (level or pulse; sampled only in IDLE).
- rxclk_ok_i  in  1  rxclk present, already sysclk-synchronous.
- busy_o  out  1  training in progress.
- done_o  out  1  training succeeded (sticky until next start).
- fail_o  out  1  training failed (sticky until next start).
- fail_code_o  out  3  0 none, 1 no eye, 2 align fail, 3 lock timeout, 4 rxclk lost.
- idelay_value_o  out  6  IDELAY tap request.
- idelay_load_o  out  1  1-cycle load strobe.
- iserdes_rst_o  out  1  ISERDES reset.
- iserdes_bitslip_o  out  1  1-cycle bitslip strobe.
- cin_sync_rst_o  out  1  parallel-sync reset.
- cin_sync_capture_o  out  1  1-cycle capture strobe.
- cin_sync_data_i  in  32  captured word.
- cin_biterr_i  in  1  per-cycle bit-error flag.
- cin_sync_lock_o  out  1  1-cycle lock request.
- cin_sync_locked_i  in  1  sync locked.
- eye_start_o  out  6  first tap of chosen eye.
- eye_width_o  out  7  eye length, 0..64.
- bitslips_o  out  2  bitslips issued.

Behaviour:
- Reset: every output 0; state IDLE; all counters and eye registers cleared. Reset mid-operation aborts immediately with no further strobes.
- States:
  - IDLE: on start_i, clear done/fail/code/eye/bitslips; go to RST.
  - RST: iserdes_rst_o and cin_sync_rst_o high for exactly 4 cycles; tap=0; go to LOAD.
  - LOAD: idelay_value_o=tap, idelay_load_o=1 for 1 cycle; go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES; go to DWELL.
  - DWELL: count cin_biterr_i for DWELL_CYCLES; the count saturates and never wraps. Go to EVAL.
  - EVAL: tap is good iff count==0.
    - Good: if run_len==0, run_start=tap; run_len++.
    - Bad: close the run.
    - Closing a run: if run_len > best_len (strict, so the lowest-tap run wins ties), then best_start=run_start and best_len=run_len; run_len=0.
    - At tap 63, close the run after evaluating the tap. No wrap-around: tap 63 and tap 0 are never joined.
    - If tap<63: tap++, go to LOAD. Otherwise, if best_len<MIN_EYE, FAIL(1); else go to CENTER.
  - CENTER: centre = best_start + ((best_len-1)>>1); load it (1-cycle strobe); eye_start_o/eye_width_o latch best_start/best_len; go to CSETTLE.
  - CSETTLE: wait SETTLE_CYCLES; go to CAP.
  - CAP: cin_sync_capture_o for 1 cycle; wait CAPTURE_WAIT; go to CHECK.
  - CHECK: aligned iff cin_sync_data_i equals TRAIN_SEQUENCE rotated left by 0,4,...,28 bits (any of 8).
    - Aligned: go to LOCK.
    - Not aligned and bitslips<3: go to SLIP.
    - Not aligned and bitslips==3: FAIL(2).
  - SLIP: iserdes_bitslip_o for 1 cycle; bitslips++; wait SETTLE_CYCLES; go to CAP.
  - LOCK: cin_sync_lock_o for 1 cycle; go to LOCKWAIT.
  - LOCKWAIT: locked_i seen within LOCK_TIMEOUT cycles → DONE; else FAIL(3).
  - DONE / FAIL: set done_o or fail_o and fail_code_o, busy_o=0, return to IDLE. Flags hold until the next accepted start.
- busy_o=1 in every state except IDLE.
- start_i while busy is ignored.
- rxclk_ok_i low in any busy state → FAIL(4) on the next cycle. This has priority over every other transition.
- At most one strobe output is high in any cycle.

Test Plan:
- biterr never asserted, data==TRAIN_SEQUENCE → 64 tap loads, centre load value 31, eye 0/64, bitslips 0, lock pulse; locked_i after 10 cycles → done_o=1, code 0.
- biterr held high except taps 20..40 → center load 30, eye_start 20, width 21.
- Good taps 5..9 and 30..34 (equal length) → eye_start 5, centre 7. Only taps 0..2 good → fail_o, code 1, no capture strobe.
- Data correct only after 2 bitslips (bench model rotates per slip) → exactly 2 bitslip strobes, bitslips_o=2, done. Never aligning → 3 strobes, code 2.
- locked_i never asserted → fail code 3 exactly LOCK_TIMEOUT cycles after lock pulse. rxclk_ok_i dropped mid-DWELL → code 4. rst_i mid-SWEEP → all outputs 0 next cycle; re-start runs a full sweep from tap 0.

Source files
------------

// File: rtl/turf_cin_autotrain_if.sv
// CIN capture-path bundle between the autotrain sequencer (master) and the
// IDELAY/ISERDES/parallel-sync logic (slave).
interface turf_cin_autotrain_if;
  logic [5:0]  idelay_value_o;
  logic        idelay_load_o;
  logic        iserdes_rst_o;
  logic        iserdes_bitslip_o;
  logic        cin_sync_rst_o;
  logic        cin_sync_capture_o;
  logic [31:0] cin_sync_data_i;
  logic        cin_biterr_i;
  logic        cin_sync_lock_o;
  logic        cin_sync_locked_i;

  modport master (
    output idelay_value_o, idelay_load_o, iserdes_rst_o, iserdes_bitslip_o,
    output cin_sync_rst_o, cin_sync_capture_o, cin_sync_lock_o,
    input  cin_sync_data_i, cin_biterr_i, cin_sync_locked_i
  );

  modport slave (
    input  idelay_value_o, idelay_load_o, iserdes_rst_o, iserdes_bitslip_o,
    input  cin_sync_rst_o, cin_sync_capture_o, cin_sync_lock_o,
    output cin_sync_data_i, cin_biterr_i, cin_sync_locked_i
  );
endinterface

// File: rtl/turf_cin_autotrain.sv
// TURF CIN autotrain: IDELAY eye sweep, centre load, bitslip alignment and
// sync lock, all sequenced in the sysclk domain.
module turf_cin_autotrain #(
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter int          SETTLE_CYCLES  = 64,
  parameter int          DWELL_CYCLES   = 4096,
  parameter int          MIN_EYE        = 4,
  parameter int          CAPTURE_WAIT   = 16,
  parameter int          LOCK_TIMEOUT   = 1024
) (
  input  logic       sysclk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rxclk_ok_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [2:0] fail_code_o,
  output logic [5:0] eye_start_o,
  output logic [6:0] eye_width_o,
  output logic [1:0] bitslips_o,
  turf_cin_autotrain_if.master cin
);
  localparam int M1      = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int M2      = (CAPTURE_WAIT > LOCK_TIMEOUT) ? CAPTURE_WAIT : LOCK_TIMEOUT;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 5);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CAPW_C   = CNT_W'(CAPTURE_WAIT);
  localparam logic [CNT_W-1:0] LOCKTO_C = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_LOAD, S_SETTLE, S_DWELL, S_EVAL, S_CENTER, S_CSETTLE,
    S_CAP, S_CAPWAIT, S_CHECK, S_SLIP, S_SLIPWAIT, S_LOCK, S_LOCKWAIT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      err_q;
  logic [5:0]       tap_q, run_start_q, best_start_q, run_start_d, best_start_d, centre;
  logic [6:0]       run_len_q, best_len_q, run_len_d, best_len_d;
  logic             busy_q, done_q, fail_q;
  logic [2:0]       code_q;
  logic [5:0]       eye_start_q, value_q;
  logic [6:0]       eye_width_q;
  logic [1:0]       slips_q;
  logic             load_q, iserdes_rst_q, sync_rst_q, bitslip_q, capture_q, lock_q;

  function automatic logic [15:0] err_sat(input logic [15:0] e, input logic hit);
    return (e == 16'hFFFF) ? e : e + {15'd0, hit};
  endfunction

  // Any nibble rotation of the training word counts as aligned.
  function automatic logic is_aligned(input logic [31:0] d);
    logic [63:0] dbl;
    logic        hit;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      dbl = {TRAIN_SEQUENCE, TRAIN_SEQUENCE} << (4 * k);
      if (d == dbl[63:32]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Run tracking for the tap under evaluation; tap 63 always closes the run.
  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (err_q == '0) begin
      if (run_len_q == '0) run_start_d = tap_q;
      run_len_d = run_len_q + 7'd1;
    end
    if (err_q != '0 || tap_q == 6'd63) begin
      if (run_len_d > best_len_q) begin
        best_start_d = run_start_d;
        best_len_d   = run_len_d;
      end
      run_len_d = '0;
    end
  end

  assign centre = best_start_d + 6'((best_len_d - 7'd1) >> 1);

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;        cnt_q <= '0;           err_q <= '0;
      tap_q <= '0;              run_start_q <= '0;     run_len_q <= '0;
      best_start_q <= '0;       best_len_q <= '0;      busy_q <= 1'b0;
      done_q <= 1'b0;           fail_q <= 1'b0;        code_q <= '0;
      eye_start_q <= '0;        eye_width_q <= '0;     slips_q <= '0;
      value_q <= '0;            load_q <= 1'b0;        iserdes_rst_q <= 1'b0;
      sync_rst_q <= 1'b0;       bitslip_q <= 1'b0;     capture_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      load_q    <= 1'b0;
      bitslip_q <= 1'b0;
      capture_q <= 1'b0;
      lock_q    <= 1'b0;
      if (state_q != S_IDLE && !rxclk_ok_i) begin
        state_q <= S_IDLE; busy_q <= 1'b0; fail_q <= 1'b1; code_q <= 3'd4;
        iserdes_rst_q <= 1'b0; sync_rst_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            busy_q <= 1'b1; done_q <= 1'b0; fail_q <= 1'b0; code_q <= '0;
            eye_start_q <= '0; eye_width_q <= '0; slips_q <= '0;
            iserdes_rst_q <= 1'b1; sync_rst_q <= 1'b1; cnt_q <= CNT_W'(1);
            state_q <= S_RST;
          end
          S_RST: if (cnt_q == CNT_W'(4)) begin
            iserdes_rst_q <= 1'b0; sync_rst_q <= 1'b0; tap_q <= '0;
            run_start_q <= '0; run_len_q <= '0; best_start_q <= '0; best_len_q <= '0;
            value_q <= '0; load_q <= 1'b1; state_q <= S_LOAD;
          end else cnt_q <= cnt_q + 1'b1;
          S_LOAD:   begin cnt_q <= CNT_W'(1); state_q <= S_SETTLE;  end
          S_CENTER: begin cnt_q <= CNT_W'(1); state_q <= S_CSETTLE; end
          S_SETTLE: if (cnt_q == SETTLE_C) begin
            cnt_q <= CNT_W'(1); err_q <= '0; state_q <= S_DWELL;
          end else cnt_q <= cnt_q + 1'b1;
          S_DWELL: begin
            err_q <= err_sat(err_q, cin.cin_biterr_i);
            if (cnt_q == DWELL_C) state_q <= S_EVAL;
            else cnt_q <= cnt_q + 1'b1;
          end
          S_EVAL: begin
            run_start_q <= run_start_d; run_len_q <= run_len_d;
            best_start_q <= best_start_d; best_len_q <= best_len_d;
            if (tap_q != 6'd63) begin
              tap_q <= tap_q + 6'd1; value_q <= tap_q + 6'd1; load_q <= 1'b1;
              state_q <= S_LOAD;
            end else if (best_len_d < 7'(MIN_EYE)) begin
              state_q <= S_IDLE; busy_q <= 1'b0; fail_q <= 1'b1; code_q <= 3'd1;
            end else begin
              value_q <= centre; load_q <= 1'b1;
              eye_start_q <= best_start_d; eye_width_q <= best_len_d;
              state_q <= S_CENTER;
            end
          end
          S_CSETTLE: if (cnt_q == SETTLE_C) begin
            capture_q <= 1'b1; state_q <= S_CAP;
          end else cnt_q <= cnt_q + 1'b1;
          S_CAP: begin cnt_q <= CNT_W'(1); state_q <= S_CAPWAIT; end
          S_CAPWAIT: if (cnt_q == CAPW_C) state_q <= S_CHECK;
                     else cnt_q <= cnt_q + 1'b1;
          S_CHECK: if (is_aligned(cin.cin_sync_data_i)) begin
            lock_q <= 1'b1; state_q <= S_LOCK;
          end else if (slips_q != 2'd3) begin
            bitslip_q <= 1'b1; slips_q <= slips_q + 2'd1; state_q <= S_SLIP;
          end else begin
            state_q <= S_IDLE; busy_q <= 1'b0; fail_q <= 1'b1; code_q <= 3'd2;
          end
          S_SLIP: begin cnt_q <= CNT_W'(1); state_q <= S_SLIPWAIT; end
          S_SLIPWAIT: if (cnt_q == SETTLE_C) begin
            capture_q <= 1'b1; state_q <= S_CAP;
          end else cnt_q <= cnt_q + 1'b1;
          S_LOCK: begin cnt_q <= CNT_W'(1); state_q <= S_LOCKWAIT; end
          // The lock-pulse cycle counts as cycle 0 of the timeout window.
          S_LOCKWAIT: if (cin.cin_sync_locked_i) begin
            state_q <= S_IDLE; busy_q <= 1'b0; done_q <= 1'b1;
          end else if (cnt_q == LOCKTO_C) begin
            state_q <= S_IDLE; busy_q <= 1'b0; fail_q <= 1'b1; code_q <= 3'd3;
          end else cnt_q <= cnt_q + 1'b1;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign fail_o                 = fail_q;
  assign fail_code_o            = code_q;
  assign eye_start_o            = eye_start_q;
  assign eye_width_o            = eye_width_q;
  assign bitslips_o             = slips_q;
  assign cin.idelay_value_o     = value_q;
  assign cin.idelay_load_o      = load_q;
  assign cin.iserdes_rst_o      = iserdes_rst_q;
  assign cin.iserdes_bitslip_o  = bitslip_q;
  assign cin.cin_sync_rst_o     = sync_rst_q;
  assign cin.cin_sync_capture_o = capture_q;
  assign cin.cin_sync_lock_o    = lock_q;
endmodule

// File: tb/tb_turf_cin_autotrain.sv
// Bench for turf_cin_autotrain: a tap-mask/bitslip/lock model of the CIN path
// drives the DUT and predicts loads, eye, strobe counts and result codes.
module tb_turf_cin_autotrain;
  localparam logic [31:0] TRAIN = 32'hA55A6996;
  localparam int S = 4, D = 8, MINE = 4, CW = 4, LT = 32;

  logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, rxclk_ok_i = 1'b1;
  logic busy_o, done_o, fail_o;
  logic [2:0] fail_code_o;
  logic [5:0] eye_start_o;
  logic [6:0] eye_width_o;
  logic [1:0] bitslips_o;

  turf_cin_autotrain_if cin ();

  turf_cin_autotrain #(
    .TRAIN_SEQUENCE(TRAIN), .SETTLE_CYCLES(S), .DWELL_CYCLES(D), .MIN_EYE(MINE),
    .CAPTURE_WAIT(CW), .LOCK_TIMEOUT(LT)
  ) dut (
    .sysclk_i(clk), .rst_i(rst_i), .start_i(start_i), .rxclk_ok_i(rxclk_ok_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_code_o(fail_code_o),
    .eye_start_o(eye_start_o), .eye_width_o(eye_width_o), .bitslips_o(bitslips_o),
    .cin(cin)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, loads_seen, slips_seen, caps_seen, locks_seen, rst_cyc, srst_cyc;
  int lock_cyc = 0, end_cyc = 0, need = 0, base = 0, lock_d = 0;
  bit lock_armed = 1'b0, end_seen = 1'b0;
  logic [63:0] good = '1;
  logic [5:0] cur_tap = '0;
  int exp_loads[$];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} << (n % 32);
    return d[63:32];
  endfunction

  // CIN path model: errors follow the loaded tap, data rotates back one bit per slip.
  assign cin.cin_biterr_i      = ~good[cur_tap];
  assign cin.cin_sync_data_i   = (need == 4) ? 32'hDEADBEEF
                               : rotl(TRAIN, 4 * base + ((need - slips_seen) & 3));
  assign cin.cin_sync_locked_i = lock_armed && (lock_d != 0) && (cyc >= lock_cyc + lock_d);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [63:0] mk(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Longest run of good taps, lowest start on ties, no wrap from 63 to 0.
  function automatic void best_run(input logic [63:0] m, output int bs, output int bl);
    logic prev;
    int   l;
    bs = 0; bl = 0; prev = 1'b0;
    for (int s = 0; s < 64; s++) begin
      if (m[s] && !prev) begin
        l = 0;
        while (s + l < 64 && m[s + l]) l++;
        if (l > bl) begin bl = l; bs = s; end
      end
      prev = m[s];
    end
  endfunction

  always @(negedge clk) begin
    int ns;
    cyc++;
    if (!rst_i) begin
      ns = int'(cin.idelay_load_o) + int'(cin.iserdes_bitslip_o)
         + int'(cin.cin_sync_capture_o) + int'(cin.cin_sync_lock_o);
      if (ns != 0) chk("strobe_onehot", ns, 1);
      if (cin.idelay_load_o) begin
        loads_seen++;
        cur_tap = cin.idelay_value_o;
        chk("load_expected", exp_loads.size() != 0, 1);
        if (exp_loads.size() != 0) chk("load_value", cin.idelay_value_o, exp_loads.pop_front());
      end
      if (cin.iserdes_bitslip_o) slips_seen++;
      if (cin.cin_sync_capture_o) caps_seen++;
      if (cin.cin_sync_lock_o) begin locks_seen++; lock_cyc = cyc; lock_armed = 1'b1; end
      if (cin.iserdes_rst_o) rst_cyc++;
      if (cin.cin_sync_rst_o) srst_cyc++;
      if ((done_o || fail_o) && !end_seen) begin end_seen = 1'b1; end_cyc = cyc; end
    end
  end

  task automatic all_zero(input string name);
    chk(name, {busy_o, done_o, fail_o, fail_code_o, eye_start_o, eye_width_o, bitslips_o,
               cin.idelay_value_o, cin.idelay_load_o, cin.iserdes_rst_o, cin.iserdes_bitslip_o,
               cin.cin_sync_rst_o, cin.cin_sync_capture_o, cin.cin_sync_lock_o}, 0);
  endtask

  task automatic do_start(input logic [63:0] m, input int nd, input int bse, input int ld);
    good = m; need = nd; base = bse; lock_d = ld;
    loads_seen = 0; slips_seen = 0; caps_seen = 0; locks_seen = 0;
    rst_cyc = 0; srst_cyc = 0; lock_armed = 1'b0;
    exp_loads.delete();
    for (int t = 0; t < 64; t++) exp_loads.push_back(t);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    end_seen = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_clears", {done_o, fail_o, fail_code_o, eye_width_o, bitslips_o}, 0);
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!end_seen && n < budget) begin @(negedge clk); n++; end
    chk("end_reached", end_seen, 1);
  endtask

  task automatic run_trial(input string tag, input logic [63:0] m, input int nd,
                           input int bse, input int ld, input bit poke);
    int bs, bl, ecode, eslips, ecaps, elocks;
    bit ok;
    best_run(m, bs, bl);
    ok = (bl >= MINE);
    do_start(m, nd, bse, ld);
    if (ok) exp_loads.push_back(bs + (bl - 1) / 2);
    if (!ok)          begin ecode = 1; eslips = 0;  ecaps = 0;      elocks = 0; end
    else if (nd == 4) begin ecode = 2; eslips = 3;  ecaps = 4;      elocks = 0; end
    else begin
      eslips = nd; ecaps = nd + 1; elocks = 1;
      ecode = (ld != 0 && ld < LT) ? 0 : 3;
    end
    if (poke) begin
      repeat (50) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_end(30000);
    repeat (2) @(negedge clk);
    chk({tag, "_loads"}, loads_seen, ok ? 65 : 64);
    chk({tag, "_loads_left"}, exp_loads.size(), 0);
    chk({tag, "_iserdes_rst_len"}, rst_cyc, 4);
    chk({tag, "_sync_rst_len"}, srst_cyc, 4);
    chk({tag, "_eye_start"}, eye_start_o, ok ? bs : 0);
    chk({tag, "_eye_width"}, eye_width_o, ok ? bl : 0);
    chk({tag, "_bitslips_o"}, bitslips_o, eslips);
    chk({tag, "_slip_strobes"}, slips_seen, eslips);
    chk({tag, "_capture_strobes"}, caps_seen, ecaps);
    chk({tag, "_lock_strobes"}, locks_seen, elocks);
    chk({tag, "_done"}, done_o, ecode == 0);
    chk({tag, "_fail"}, fail_o, ecode != 0);
    chk({tag, "_code"}, fail_code_o, ecode);
    chk({tag, "_busy"}, busy_o, 0);
    if (elocks == 1) chk({tag, "_lock_latency"}, end_cyc - lock_cyc, (ecode == 0) ? ld + 1 : LT);
  endtask

  initial begin
    int bs, bl, n;
    repeat (3) @(negedge clk);
    all_zero("reset_outputs");
    rst_i = 1'b0;
    @(negedge clk);

    best_run('1, bs, bl);
    chk("model_all_start", bs, 0); chk("model_all_len", bl, 64);
    chk("model_all_centre", bs + (bl - 1) / 2, 31);
    best_run(mk(20, 40), bs, bl);
    chk("model_mid_start", bs, 20); chk("model_mid_len", bl, 21);
    chk("model_mid_centre", bs + (bl - 1) / 2, 30);
    best_run(mk(5, 9) | mk(30, 34), bs, bl);
    chk("model_tie_start", bs, 5); chk("model_tie_centre", bs + (bl - 1) / 2, 7);
    best_run(mk(0, 1) | mk(60, 63), bs, bl);
    chk("model_nowrap_start", bs, 60); chk("model_nowrap_len", bl, 4);

    run_trial("allgood",   '1,                    0, 0, 10, 1'b0);
    run_trial("mid_eye",   mk(20, 40),            1, 2, 5,  1'b1);
    run_trial("tie",       mk(5, 9) | mk(30, 34), 2, 0, 3,  1'b0);
    run_trial("no_eye",    mk(0, 2),              0, 0, 10, 1'b0);
    run_trial("nowrap",    mk(0, 1) | mk(60, 63), 3, 5, 1,  1'b0);
    run_trial("no_align",  mk(10, 30),            4, 0, 10, 1'b0);
    run_trial("rot8",      mk(10, 30),            0, 2, 7,  1'b0);
    run_trial("lock_never", '1,                   0, 0, 0,  1'b0);
    run_trial("lock_late",  '1,                   1, 1, LT, 1'b0);
    run_trial("lock_last",  '1,                   0, 3, LT - 1, 1'b0);

    // rxclk drop while dwelling on tap 5
    do_start('1, 0, 0, 10);
    n = 0;
    while (!(cin.idelay_load_o && cin.idelay_value_o == 6'd5) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("rxdrop_reached_tap5", n < 2000, 1);
    repeat (S + 3) @(negedge clk);
    chk("rxdrop_before", fail_o, 0);
    rxclk_ok_i = 1'b0;
    @(negedge clk);
    chk("rxdrop_fail", fail_o, 1);
    chk("rxdrop_code", fail_code_o, 4);
    chk("rxdrop_busy", busy_o, 0);
    rxclk_ok_i = 1'b1;
    repeat (40) @(negedge clk);
    chk("rxdrop_no_more_loads", loads_seen, 6);

    // reset in the middle of the sweep, then a full clean rerun
    do_start('1, 0, 0, 10);
    n = 0;
    while (!(cin.idelay_load_o && cin.idelay_value_o == 6'd10) && n < 4000) begin
      @(negedge clk); n++;
    end
    chk("rst_reached_tap10", n < 4000, 1);
    rst_i = 1'b1;
    @(negedge clk);
    all_zero("midsweep_reset_outputs");
    rst_i = 1'b0;
    @(negedge clk);
    run_trial("after_rst", '1, 0, 0, 10, 1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [63:0] m;
      for (int t = 0; t < 64; t++) m[t] = ($urandom_range(0, 9) != 0);
      run_trial($sformatf("rand%0d", r), m, $urandom_range(0, 4), $urandom_range(0, 7),
                $urandom_range(0, LT + 3), r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
